lnrv_icb_arbiter: RTL and testbench

Shares one downstream ICB slave port (for example the ICB side feeding a peripheral bus or the command input of an ICB target) among P_MASTER_NUM upstream ICB masters, such as several AXI-to-ICB bridges and core LSU ports. Command arbitration is round-robin. A tag FIFO records the source of each issued command, and in-order responses are routed back to that source. The block sits in the bus fabric between ICB masters and a single in-order ICB slave.

---
 rtl/lnrv_icb_pkg.sv | 18 +
 rtl/lnrv_icb_arbt_tagq.sv | 70 +++++++
 rtl/lnrv_icb_arbiter.sv | 138 +++++++++++++
 tb/tb_lnrv_icb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lnrv_icb_pkg.sv
// lnrv_icb_pkg
// Shared ICB definitions for the arbiter slice.
//   - ICB size field encodings (byte/half/word)
//   - tag_width(n): number of bits needed to name one of n masters, minimum 1
package lnrv_icb_pkg;

    localparam logic [2:0] ICB_SIZE_BYTE = 3'd0;
    localparam logic [2:0] ICB_SIZE_HALF = 3'd1;
    localparam logic [2:0] ICB_SIZE_WORD = 3'd2;

    function automatic int tag_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/lnrv_icb_arbt_tagq.sv
// lnrv_icb_arbt_tagq
// Synchronous tag FIFO recording which master issued each outstanding command.
// Pointer-plus-count organisation; head is the tag of the oldest entry.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset (clears to empty)
//   push, push_tag     enqueue a tag (ignored while full)
//   pop                dequeue the head (ignored while empty)
//   full, empty        occupancy flags
//   head               tag at the front of the queue
module lnrv_icb_arbt_tagq #(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_tag,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [P_WIDTH-1:0] head
);

    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CW = $clog2(P_DEPTH + 1);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      cnt;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(P_DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/lnrv_icb_arbiter.sv
// lnrv_icb_arbiter
// Shares one in-order downstream ICB slave among P_MASTER_NUM upstream masters.
// Commands: combinational round-robin grant and field mux, zero added latency.
// Responses: routed back to the master recorded at the head of the tag FIFO.
// Build option: define LNRV_ICB_ARBT_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no rotating pointer).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m_icb_cmd_*                  packed per-master command channels (master i at slice i)
//   m_icb_rsp_*                  per-master response channels (rdata broadcast)
//   s_icb_cmd_*                  downstream command channel
//   s_icb_rsp_*                  downstream response channel
module lnrv_icb_arbiter
    import lnrv_icb_pkg::*;
#(
    parameter int P_MASTER_NUM = 2,
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_OTS_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [P_MASTER_NUM-1:0]               m_icb_cmd_vld,
    output logic [P_MASTER_NUM-1:0]               m_icb_cmd_rdy,
    input  logic [P_MASTER_NUM-1:0]               m_icb_cmd_write,
    input  logic [P_MASTER_NUM*P_ADDR_WIDTH-1:0]  m_icb_cmd_addr,
    input  logic [P_MASTER_NUM*P_DATA_WIDTH-1:0]  m_icb_cmd_wdata,
    input  logic [P_MASTER_NUM*P_DATA_WIDTH/8-1:0] m_icb_cmd_wstrb,
    input  logic [P_MASTER_NUM*3-1:0]             m_icb_cmd_size,
    output logic [P_MASTER_NUM-1:0]               m_icb_rsp_vld,
    input  logic [P_MASTER_NUM-1:0]               m_icb_rsp_rdy,
    output logic [P_MASTER_NUM-1:0]               m_icb_rsp_err,
    output logic [P_MASTER_NUM*P_DATA_WIDTH-1:0]  m_icb_rsp_rdata,
    output logic                                  s_icb_cmd_vld,
    input  logic                                  s_icb_cmd_rdy,
    output logic                                  s_icb_cmd_write,
    output logic [P_ADDR_WIDTH-1:0]               s_icb_cmd_addr,
    output logic [P_DATA_WIDTH-1:0]               s_icb_cmd_wdata,
    output logic [P_DATA_WIDTH/8-1:0]             s_icb_cmd_wstrb,
    output logic [2:0]                            s_icb_cmd_size,
    input  logic                                  s_icb_rsp_vld,
    output logic                                  s_icb_rsp_rdy,
    input  logic                                  s_icb_rsp_err,
    input  logic [P_DATA_WIDTH-1:0]               s_icb_rsp_rdata
);

    localparam int TW = tag_width(P_MASTER_NUM);
    localparam int SW = P_DATA_WIDTH / 8;

    logic [TW-1:0]           rr_ptr;
    logic [TW-1:0]           winner;
    logic                    found;
    logic [P_MASTER_NUM-1:0] grant;
    logic                    cmd_hsk;
    logic                    rsp_hsk;
    logic                    tq_full;
    logic                    tq_empty;
    logic [TW-1:0]           tq_head;

    // Cyclic search starting at rr_ptr; the first requester wins.
    always_comb begin : p_grant
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < P_MASTER_NUM; k++) begin
            idx = (int'(rr_ptr) + k) % P_MASTER_NUM;
            if (!found && m_icb_cmd_vld[idx]) begin
                found  = 1'b1;
                winner = TW'(idx);
            end
        end
        grant = '0;
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        s_icb_cmd_write = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wstrb = '0;
        s_icb_cmd_size  = '0;
        if (found) begin
            s_icb_cmd_write = m_icb_cmd_write[winner];
            s_icb_cmd_addr  = m_icb_cmd_addr[int'(winner)*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            s_icb_cmd_wdata = m_icb_cmd_wdata[int'(winner)*P_DATA_WIDTH +: P_DATA_WIDTH];
            s_icb_cmd_wstrb = m_icb_cmd_wstrb[int'(winner)*SW +: SW];
            s_icb_cmd_size  = m_icb_cmd_size[int'(winner)*3 +: 3];
        end
    end

    // A full tag queue blocks commands even if a response pops this cycle,
    // keeping the ready path free of the response handshake.
    assign s_icb_cmd_vld = found & ~tq_full;
    assign m_icb_cmd_rdy = grant & {P_MASTER_NUM{s_icb_cmd_rdy & ~tq_full}};
    assign cmd_hsk       = s_icb_cmd_vld & s_icb_cmd_rdy;

`ifdef LNRV_ICB_ARBT_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (cmd_hsk) begin
            rr_ptr <= (int'(winner) == P_MASTER_NUM - 1) ? '0 : winner + 1'b1;
        end
    end
`endif

    always_comb begin
        m_icb_rsp_vld = '0;
        if (!tq_empty) begin
            m_icb_rsp_vld[tq_head] = s_icb_rsp_vld;
        end
    end

    assign m_icb_rsp_err   = m_icb_rsp_vld & {P_MASTER_NUM{s_icb_rsp_err}};
    assign m_icb_rsp_rdata = {P_MASTER_NUM{s_icb_rsp_rdata}};
    assign s_icb_rsp_rdy   = ~tq_empty & m_icb_rsp_rdy[tq_head];
    assign rsp_hsk         = s_icb_rsp_vld & s_icb_rsp_rdy;

    lnrv_icb_arbt_tagq #(
        .P_DEPTH (P_OTS_DEPTH),
        .P_WIDTH (TW)
    ) u_tagq (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (cmd_hsk),
        .push_tag (winner),
        .pop      (rsp_hsk),
        .full     (tq_full),
        .empty    (tq_empty),
        .head     (tq_head)
    );

endmodule

// File: tb/tb_lnrv_icb_arbiter.sv
// tb_lnrv_icb_arbiter
// Directed scenarios with literal expectations followed by randomized traffic,
// all checked every cycle against a queue-based model of the arbiter.
module tb_lnrv_icb_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int D  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      m_icb_cmd_vld = '0;
    logic [N-1:0]      m_icb_cmd_rdy;
    logic [N-1:0]      m_icb_cmd_write = '0;
    logic [N*AW-1:0]   m_icb_cmd_addr = '0;
    logic [N*DW-1:0]   m_icb_cmd_wdata = '0;
    logic [N*SW-1:0]   m_icb_cmd_wstrb = '0;
    logic [N*3-1:0]    m_icb_cmd_size = '0;
    logic [N-1:0]      m_icb_rsp_vld;
    logic [N-1:0]      m_icb_rsp_rdy = '0;
    logic [N-1:0]      m_icb_rsp_err;
    logic [N*DW-1:0]   m_icb_rsp_rdata;
    logic              s_icb_cmd_vld;
    logic              s_icb_cmd_rdy = 1'b0;
    logic              s_icb_cmd_write;
    logic [AW-1:0]     s_icb_cmd_addr;
    logic [DW-1:0]     s_icb_cmd_wdata;
    logic [SW-1:0]     s_icb_cmd_wstrb;
    logic [2:0]        s_icb_cmd_size;
    logic              s_icb_rsp_vld = 1'b0;
    logic              s_icb_rsp_rdy;
    logic              s_icb_rsp_err = 1'b0;
    logic [DW-1:0]     s_icb_rsp_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    lnrv_icb_arbiter #(
        .P_MASTER_NUM (N),
        .P_ADDR_WIDTH (AW),
        .P_DATA_WIDTH (DW),
        .P_OTS_DEPTH  (D)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m_icb_cmd_vld   (m_icb_cmd_vld),
        .m_icb_cmd_rdy   (m_icb_cmd_rdy),
        .m_icb_cmd_write (m_icb_cmd_write),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wstrb (m_icb_cmd_wstrb),
        .m_icb_cmd_size  (m_icb_cmd_size),
        .m_icb_rsp_vld   (m_icb_rsp_vld),
        .m_icb_rsp_rdy   (m_icb_rsp_rdy),
        .m_icb_rsp_err   (m_icb_rsp_err),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .s_icb_cmd_vld   (s_icb_cmd_vld),
        .s_icb_cmd_rdy   (s_icb_cmd_rdy),
        .s_icb_cmd_write (s_icb_cmd_write),
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wstrb (s_icb_cmd_wstrb),
        .s_icb_cmd_size  (s_icb_cmd_size),
        .s_icb_rsp_vld   (s_icb_rsp_vld),
        .s_icb_rsp_rdy   (s_icb_rsp_rdy),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .s_icb_rsp_rdata (s_icb_rsp_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int q[$];      // master index of each outstanding command, oldest first
    int rr = 0;

    logic            e_any;
    int              e_g;
    logic            e_s_cmd_vld;
    logic [N-1:0]    e_m_cmd_rdy;
    logic            e_write;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [SW-1:0]   e_wstrb;
    logic [2:0]      e_size;
    logic [N-1:0]    e_m_rsp_vld;
    logic [N-1:0]    e_m_rsp_err;
    logic [N*DW-1:0] e_rdata;
    logic            e_s_rsp_rdy;

    function automatic void model_eval();
        bit is_full, is_empty;
        int start;
        is_full  = (q.size() == D);
        is_empty = (q.size() == 0);
`ifdef LNRV_ICB_ARBT_FIXED_PRIO_EN
        start = 0;
`else
        start = rr;
`endif
        e_any = 1'b0;
        e_g   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m_icb_cmd_vld[(start + k) % N]) begin
                e_any = 1'b1;
                e_g   = (start + k) % N;
            end
        end
        e_s_cmd_vld = e_any && !is_full;
        e_m_cmd_rdy = '0;
        e_write = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0; e_size = '0;
        if (e_any) begin
            e_m_cmd_rdy[e_g] = s_icb_cmd_rdy && !is_full;
            e_write = m_icb_cmd_write[e_g];
            e_addr  = m_icb_cmd_addr[e_g*AW +: AW];
            e_wdata = m_icb_cmd_wdata[e_g*DW +: DW];
            e_wstrb = m_icb_cmd_wstrb[e_g*SW +: SW];
            e_size  = m_icb_cmd_size[e_g*3 +: 3];
        end
        e_m_rsp_vld = '0;
        e_s_rsp_rdy = 1'b0;
        if (!is_empty) begin
            e_m_rsp_vld[q[0]] = s_icb_rsp_vld;
            e_s_rsp_rdy = m_icb_rsp_rdy[q[0]];
        end
        e_m_rsp_err = s_icb_rsp_err ? e_m_rsp_vld : '0;
        for (int i = 0; i < N; i++) e_rdata[i*DW +: DW] = s_icb_rsp_rdata;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            rr <= 0;
        end else begin
            model_eval();
            if (e_s_rsp_rdy && s_icb_rsp_vld) void'(q.pop_front());
            if (e_s_cmd_vld && s_icb_cmd_rdy) begin
                q.push_back(e_g);
                rr <= (e_g + 1) % N;
            end
        end
    end

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        model_eval();
        cmp("s_cmd_vld",   128'(s_icb_cmd_vld),   128'(e_s_cmd_vld));
        cmp("m_cmd_rdy",   128'(m_icb_cmd_rdy),   128'(e_m_cmd_rdy));
        cmp("s_cmd_write", 128'(s_icb_cmd_write), 128'(e_write));
        cmp("s_cmd_addr",  128'(s_icb_cmd_addr),  128'(e_addr));
        cmp("s_cmd_wdata", 128'(s_icb_cmd_wdata), 128'(e_wdata));
        cmp("s_cmd_wstrb", 128'(s_icb_cmd_wstrb), 128'(e_wstrb));
        cmp("s_cmd_size",  128'(s_icb_cmd_size),  128'(e_size));
        cmp("m_rsp_vld",   128'(m_icb_rsp_vld),   128'(e_m_rsp_vld));
        cmp("m_rsp_err",   128'(m_icb_rsp_err),   128'(e_m_rsp_err));
        cmp("m_rsp_rdata", 128'(m_icb_rsp_rdata), 128'(e_rdata));
        cmp("s_rsp_rdy",   128'(s_icb_rsp_rdy),   128'(e_s_rsp_rdy));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    logic [N-1:0] rr_exp;

    initial begin
        // reset state
        at_neg();
        cmp("rst_s_rsp_rdy", 128'(s_icb_rsp_rdy), 128'd0);
        cmp("rst_m_rsp_vld", 128'(m_icb_rsp_vld), 128'd0);
        step();
        reset_n = 1'b1;

        // round-robin: both request, slave ready, no responses -> fills the queue
        m_icb_cmd_vld = 2'b11;
        s_icb_cmd_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
`ifdef LNRV_ICB_ARBT_FIXED_PRIO_EN
            rr_exp = 2'b01;
`else
            rr_exp = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
            at_neg();
            cmp("rr_grant", 128'(m_icb_cmd_rdy), 128'(rr_exp));
            step();
        end

        // outstanding limit reached
        at_neg();
        cmp("full_s_cmd_vld", 128'(s_icb_cmd_vld), 128'd0);
        cmp("full_m_cmd_rdy", 128'(m_icb_cmd_rdy), 128'd0);
        step();
        s_icb_rsp_vld = 1'b1; s_icb_rsp_rdata = 32'hA; m_icb_rsp_rdy = 2'b11;
        at_neg();
        cmp("pop_m_rsp_vld",  128'(m_icb_rsp_vld), 128'h1);
        cmp("pop_s_rsp_rdy",  128'(s_icb_rsp_rdy), 128'h1);
        cmp("pop_s_cmd_vld",  128'(s_icb_cmd_vld), 128'd0);
        step();
        s_icb_rsp_vld = 1'b0;
        at_neg();
        cmp("rel_s_cmd_vld",  128'(s_icb_cmd_vld), 128'h1);
        cmp("rel_m_cmd_rdy",  128'(m_icb_cmd_rdy), 128'h1);
        step();

        // backpressure: head is master 1, which is not ready
        m_icb_cmd_vld = 2'b00;
        s_icb_rsp_vld = 1'b1; s_icb_rsp_err = 1'b1; m_icb_rsp_rdy = 2'b01;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            cmp("bp_s_rsp_rdy", 128'(s_icb_rsp_rdy), 128'd0);
            cmp("bp_m_rsp_vld", 128'(m_icb_rsp_vld), 128'h2);
            cmp("bp_m_rsp_err", 128'(m_icb_rsp_err), 128'h2);
            step();
        end

        // reset with commands outstanding
        s_icb_rsp_err = 1'b0;
        reset_n = 1'b0;
        at_neg();
        cmp("mrst_s_rsp_rdy", 128'(s_icb_rsp_rdy), 128'd0);
        cmp("mrst_m_rsp_vld", 128'(m_icb_rsp_vld), 128'd0);
        step();
        reset_n = 1'b1;
        s_icb_rsp_vld = 1'b0;
        s_icb_cmd_rdy = 1'b0;
        m_icb_cmd_vld = 2'b11;
        m_icb_cmd_addr = {32'h2000, 32'h1000};
        at_neg();
        cmp("mrst_grant_addr", 128'(s_icb_cmd_addr), 128'h1000);
        step();

        // single master read, response two cycles later
        m_icb_cmd_vld = 2'b10; s_icb_cmd_rdy = 1'b1;
        m_icb_cmd_addr = {32'h100, 32'h0};
        m_icb_rsp_rdy = 2'b11;
        at_neg();
        cmp("sm_addr", 128'(s_icb_cmd_addr), 128'h100);
        cmp("sm_rdy",  128'(m_icb_cmd_rdy),  128'h2);
        step();
        m_icb_cmd_vld = 2'b00;
        step();
        s_icb_rsp_vld = 1'b1; s_icb_rsp_rdata = 32'hCAFE;
        at_neg();
        cmp("sm_rsp_vld",   128'(m_icb_rsp_vld), 128'h2);
        cmp("sm_rsp_rdata", 128'(m_icb_rsp_rdata[63:32]), 128'hCAFE);
        step();
        s_icb_rsp_vld = 1'b0;

        // ordering: M0, M1, M0 then responses A, B, C
        m_icb_cmd_vld = 2'b01; step();
        m_icb_cmd_vld = 2'b10; step();
        m_icb_cmd_vld = 2'b01; step();
        m_icb_cmd_vld = 2'b00;
        s_icb_rsp_vld = 1'b1; s_icb_rsp_rdata = 32'hA;
        at_neg();
        cmp("ord_vld0", 128'(m_icb_rsp_vld), 128'h1);
        cmp("ord_dat0", 128'(m_icb_rsp_rdata[31:0]), 128'hA);
        step();
        s_icb_rsp_rdata = 32'hB;
        at_neg();
        cmp("ord_vld1", 128'(m_icb_rsp_vld), 128'h2);
        cmp("ord_dat1", 128'(m_icb_rsp_rdata[63:32]), 128'hB);
        step();
        s_icb_rsp_rdata = 32'hC;
        at_neg();
        cmp("ord_vld2", 128'(m_icb_rsp_vld), 128'h1);
        cmp("ord_dat2", 128'(m_icb_rsp_rdata[31:0]), 128'hC);
        step();
        s_icb_rsp_vld = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            m_icb_cmd_vld   = N'($urandom);
            m_icb_cmd_write = N'($urandom);
            m_icb_cmd_addr  = {$urandom, $urandom};
            m_icb_cmd_wdata = {$urandom, $urandom};
            m_icb_cmd_wstrb = (N*SW)'($urandom);
            m_icb_cmd_size  = (N*3)'($urandom);
            m_icb_rsp_rdy   = ($urandom_range(0, 3) != 0) ? N'($urandom) | N'(1) : N'($urandom);
            s_icb_cmd_rdy   = ($urandom_range(0, 3) != 0);
            s_icb_rsp_vld   = ($urandom_range(0, 2) != 0);
            s_icb_rsp_err   = $urandom_range(0, 1);
            s_icb_rsp_rdata = $urandom;
            step();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
